// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache line data SRAM read arbiter.
// Latency: n/a (types and a combinational helper function only).
// Backpressure: n/a.
package cache_pkg;

    typedef enum logic [1:0] {
        PRI_LOW    = 2'd0,
        PRI_MED    = 2'd1,
        PRI_HIGH   = 2'd2,
        PRI_URGENT = 2'd3
    } mem_pri_t;

    // BLOCKED: the write port owns the macro (or reset is active), so every grant is masked.
    typedef enum logic {
        NORMAL  = 1'b0,
        BLOCKED = 1'b1
    } arb_state_t;

    // Round-robin pick over the low n bits of req. The scan starts at ptr and
    // moves upward, wrapping modulo n. Returns a one-hot vector, or zero when
    // req is empty. The vector is sized for the largest supported requester
    // count (8).
    function automatic logic [7:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int         n);
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       found;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = 3'((int'(ptr) + k) % n);
            if (k < n && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/cache_rd_arb_pipe.sv
// Delays the one-hot read grant so that it lines up with the returning SRAM data.
// Latency: MEM_LAT cycles from grant to valid. Reset clears every in-flight read.
// Backpressure: none; a new grant can enter the pipe every cycle.
// Ports: clk, rst (async, active-high), grant (one-hot in), valid (one-hot out).
module cache_rd_arb_pipe #(
    parameter int NUM_REQ = 3,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] valid
);

    logic [NUM_REQ-1:0] stage [MEM_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MEM_LAT; k++) stage[k] <= '0;
        end else begin
            stage[0] <= grant;
            for (int k = 1; k < MEM_LAT; k++) stage[k] <= stage[k-1];
        end
    end

    assign valid = stage[MEM_LAT-1];

endmodule

// File: rtl/cache_rd_arb.sv
// Arbitrates the single read port of the cache line data SRAM among NUM_REQ requesters.
// Latency: the grant is issued combinationally in the request cycle; the data valid follows MEM_LAT cycles later.
// Backpressure: sram_busy masks all grants; an ungranted requester simply holds req_ren.
// Ports: clk, rst (async, active-high); req_ren/req_raddr/req_rpri in, req_rready/req_rdata/
//        req_rdata_valid out; sram_busy, sram_rdata in; sram_ren, sram_raddr out.
// Optional: define CACHE_RD_ARB_AGING_EN to promote starved requesters to top priority.
module cache_rd_arb
    import cache_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int LIST_DEPTH = 4,
    parameter int LIST_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_LAT    = 1,
    parameter int AGE_MAX    = 15,
    localparam int RADDR_W   = $clog2(LIST_DEPTH) + $clog2(LIST_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_ren,
    input  logic [NUM_REQ*RADDR_W-1:0] req_raddr,
    input  logic [NUM_REQ*2-1:0]       req_rpri,
    output logic [NUM_REQ-1:0]         req_rready,
    output logic [DATA_WIDTH-1:0]      req_rdata,
    output logic [NUM_REQ-1:0]         req_rdata_valid,
    input  logic                       sram_busy,
    output logic                       sram_ren,
    output logic [RADDR_W-1:0]         sram_raddr,
    input  logic [DATA_WIDTH-1:0]      sram_rdata
);

    localparam int         PTR_W    = $clog2(NUM_REQ);
    localparam logic [7:0] REQ_MASK = 8'((1 << NUM_REQ) - 1);

    arb_state_t         arb_state;
    mem_pri_t           eff_pri [NUM_REQ];
    mem_pri_t           top_pri;
    logic [7:0]         cand_ext;
    logic [7:0]         pick_vec;
    logic               pick_unused;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win_idx;

    // Holding reset in BLOCKED keeps the combinational grant low during reset.
    assign arb_state = (sram_busy || rst) ? BLOCKED : NORMAL;

`ifdef CACHE_RD_ARB_AGING_EN
    // Per-requester count of consecutive denied cycles, saturating at AGE_MAX.
    logic [7:0] age [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eff_pri[i] = (age[i] == 8'(AGE_MAX)) ? PRI_URGENT : mem_pri_t'(req_rpri[2*i +: 2]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ren[i] && !grant[i]) begin
                    if (age[i] != 8'(AGE_MAX)) age[i] <= age[i] + 8'd1;
                end else begin
                    age[i] <= '0;
                end
            end
        end
    end
`else
    localparam int unused_age_max = AGE_MAX;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eff_pri[i] = mem_pri_t'(req_rpri[2*i +: 2]);
        end
    end
`endif

    // Find the highest effective priority among the requesters. Only the
    // requesters at that level take part in the round-robin pick.
    always_comb begin
        top_pri  = PRI_LOW;
        cand_ext = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ren[i] && (eff_pri[i] > top_pri)) top_pri = eff_pri[i];
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_ext[i] = req_ren[i] && (eff_pri[i] == top_pri) && (arb_state == NORMAL);
        end
    end

    assign pick_vec    = rr_pick(cand_ext, 3'(rr_ptr), NUM_REQ);
    assign grant       = pick_vec[NUM_REQ-1:0];
    assign pick_unused = |(pick_vec & ~REQ_MASK);

    always_comb begin
        win_idx    = '0;
        sram_raddr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_idx    = PTR_W'(i);
                sram_raddr = req_raddr[i*RADDR_W +: RADDR_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (|grant) begin
            rr_ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    assign req_rready = grant;
    assign sram_ren   = |grant;
    assign req_rdata  = sram_rdata;

    cache_rd_arb_pipe #(
        .NUM_REQ (NUM_REQ),
        .MEM_LAT (MEM_LAT)
    ) u_pipe (
        .clk   (clk),
        .rst   (rst),
        .grant (grant),
        .valid (req_rdata_valid)
    );

endmodule

// File: tb/tb_cache_rd_arb.sv
// Bench for cache_rd_arb: two instances (MEM_LAT 1 and 3) driven by the same stimulus.
// Both are compared every cycle against a behavioural reference model.
// Stimulus: directed scenarios followed by randomized traffic with busy and reset events.
module tb_cache_rd_arb;

    localparam int NR      = 3;
    localparam int AW      = 7;
    localparam int DW      = 32;
    localparam int AGE_MAX = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_ren;
    logic [NR*AW-1:0] req_raddr;
    logic [NR*2-1:0] req_rpri;
    logic            sram_busy;
    logic [DW-1:0]   sram_rdata;

    logic [NR-1:0]   rready1, rready3, valid1, valid3;
    logic [DW-1:0]   rdata1, rdata3;
    logic            ren1, ren3;
    logic [AW-1:0]   raddr1, raddr3;

    always #5 clk = ~clk;

    cache_rd_arb #(.NUM_REQ(NR), .LIST_DEPTH(4), .LIST_WIDTH(32), .DATA_WIDTH(DW),
                   .MEM_LAT(1), .AGE_MAX(AGE_MAX)) u_dut1 (
        .clk(clk), .rst(rst), .req_ren(req_ren), .req_raddr(req_raddr), .req_rpri(req_rpri),
        .req_rready(rready1), .req_rdata(rdata1), .req_rdata_valid(valid1),
        .sram_busy(sram_busy), .sram_ren(ren1), .sram_raddr(raddr1), .sram_rdata(sram_rdata));

    cache_rd_arb #(.NUM_REQ(NR), .LIST_DEPTH(4), .LIST_WIDTH(32), .DATA_WIDTH(DW),
                   .MEM_LAT(3), .AGE_MAX(AGE_MAX)) u_dut3 (
        .clk(clk), .rst(rst), .req_ren(req_ren), .req_raddr(req_raddr), .req_rpri(req_rpri),
        .req_rready(rready3), .req_rdata(rdata3), .req_rdata_valid(valid3),
        .sram_busy(sram_busy), .sram_ren(ren3), .sram_raddr(raddr3), .sram_rdata(sram_rdata));

    // Stimulus knobs per requester
    logic          ren_a  [NR];
    logic [AW-1:0] addr_a [NR];
    int            pri_a  [NR];

    // Reference model state
    int            m_ptr;
    int            m_age [NR];
    logic [NR-1:0] grant_hist [0:1023];
    int            cyc;
    int            last_rst;
    logic [NR-1:0] last_g;
    logic [AW-1:0] last_addr;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    // A read launched l cycles ago returns now, unless a reset came after the launch.
    function automatic logic [NR-1:0] exp_valid(input int l);
        if (cyc - l >= 0 && cyc - l > last_rst) return grant_hist[cyc - l];
        return '0;
    endfunction

    // Runs one cycle. Inputs are applied just after the negedge. Outputs are
    // checked 2 time units later. The model then advances, and the task waits
    // for the next negedge.
    task automatic step();
        int            ep [NR];
        int            top;
        int            win;
        logic [NR-1:0] eg;
        logic [AW-1:0] ea;
        for (int i = 0; i < NR; i++) begin
            req_ren[i]            = ren_a[i];
            req_raddr[i*AW +: AW] = addr_a[i];
            req_rpri[i*2 +: 2]    = 2'(pri_a[i]);
        end
        sram_rdata = $urandom;
        if (rst) begin
            m_ptr    = 0;
            for (int i = 0; i < NR; i++) m_age[i] = 0;
            last_rst = cyc;
        end
        win = -1;
        if (!rst && !sram_busy) begin
            top = -1;
            for (int i = 0; i < NR; i++) begin
                ep[i] = pri_a[i];
`ifdef CACHE_RD_ARB_AGING_EN
                if (m_age[i] == AGE_MAX) ep[i] = 3;
`endif
                if (ren_a[i] && ep[i] > top) top = ep[i];
            end
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (m_ptr + k) % NR;
                if (win < 0 && ren_a[j] && ep[j] == top) win = j;
            end
        end
        eg = (win >= 0) ? NR'(1 << win) : '0;
        ea = (win >= 0) ? addr_a[win] : '0;
        grant_hist[cyc] = eg;
        #2;
        last_g    = rready1;
        last_addr = raddr1;
        check("grant_l1",  64'(rready1), 64'(eg));
        check("grant_l3",  64'(rready3), 64'(eg));
        check("sram_ren",  64'(ren1),    64'(win >= 0));
        check("sram_ren3", 64'(ren3),    64'(win >= 0));
        check("sram_raddr", 64'(raddr1), 64'(ea));
        check("valid_l1",  64'(valid1),  64'(exp_valid(1)));
        check("valid_l3",  64'(valid3),  64'(exp_valid(3)));
        check("rdata",     64'(rdata1),  64'(sram_rdata));
        if (!rst) begin
            if (win >= 0) m_ptr = (win + 1) % NR;
            for (int i = 0; i < NR; i++) begin
                if (ren_a[i] && i != win) m_age[i] = (m_age[i] < AGE_MAX) ? m_age[i] + 1 : AGE_MAX;
                else m_age[i] = 0;
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic en, input logic [AW-1:0] a, input int p);
        ren_a[i]  = en;
        addr_a[i] = a;
        pri_a[i]  = p;
    endtask

    initial begin
        cyc       = 0;
        last_rst  = -100;
        m_ptr     = 0;
        rst       = 1'b1;
        sram_busy = 1'b0;
        sram_rdata = '0;
        req_ren   = '0;
        req_raddr = '0;
        req_rpri  = '0;
        for (int i = 0; i < NR; i++) begin
            set_req(i, 1'b0, '0, 0);
            m_age[i] = 0;
        end
        @(negedge clk);

        // Reset: every output must be low
        step();
        step();
        rst = 1'b0;

        // A single request is granted in the same cycle, and its valid follows one cycle later
        set_req(0, 1'b1, 7'h2A, 0);
        step();
        check("single_grant", 64'(last_g), 64'h1);
        check("single_addr",  64'(last_addr), 64'h2A);
        set_req(0, 1'b0, 7'h2A, 0);
        repeat (3) step();

        // Equal-priority contention cycles round-robin
        set_req(0, 1'b1, 7'h10, 0);
        set_req(1, 1'b1, 7'h11, 0);
        set_req(2, 1'b1, 7'h12, 0);
        repeat (6) step();

        // Requester 1 at priority 2 against requester 2 at priority 0
        set_req(0, 1'b0, 7'h00, 0);
        set_req(1, 1'b1, 7'h21, 2);
        set_req(2, 1'b1, 7'h22, 0);
        repeat (20) step();
        set_req(1, 1'b0, 7'h21, 0);
        set_req(2, 1'b0, 7'h22, 0);
        step();

        // sram_busy blocks the read port for three cycles
        set_req(0, 1'b1, 7'h33, 1);
        sram_busy = 1'b1;
        repeat (3) step();
        sram_busy = 1'b0;
        step();
        check("busy_release_grant", 64'(last_g), 64'h1);
        set_req(0, 1'b0, 7'h33, 0);

        // Back-to-back grants to requesters 0, 1 and 2
        set_req(0, 1'b1, 7'h40, 0); step(); set_req(0, 1'b0, 7'h40, 0);
        set_req(1, 1'b1, 7'h41, 0); step(); set_req(1, 1'b0, 7'h41, 0);
        set_req(2, 1'b1, 7'h42, 0); step(); set_req(2, 1'b0, 7'h42, 0);
        repeat (4) step();

        // Reset while a read is in flight: its valid is dropped and the pointer returns to 0
        set_req(1, 1'b1, 7'h51, 0);
        step();
        set_req(1, 1'b0, 7'h51, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 1'b1, 7'h60, 0);
        set_req(1, 1'b1, 7'h61, 0);
        set_req(2, 1'b1, 7'h62, 0);
        step();
        check("post_reset_tie", 64'(last_g), 64'h1);
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, 0);
        repeat (3) step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                set_req(i, 1'($urandom_range(0, 3) != 0), 7'($urandom), int'($urandom_range(0, 3)));
            end
            sram_busy = ($urandom_range(0, 7) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            step();
        end
        rst       = 1'b0;
        sram_busy = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, 0);
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_rd_arb.md
# cache_rd_arb

Arbiter for the single read port of the cache line data SRAM (`list_depth` lines × `list_width` words). It sits between the SRAM and NUM_REQ controllers: the read controller, the write controller's read-modify path and the fetch engine's write-back drain. Each cycle it grants at most one `mem_ren` request. It routes the returned data valid back to the granted requester after the SRAM's fixed read latency. Starved low-priority requesters are aged up to top priority.

## Interface
- NUM_REQ, 3: number of requesters, 2..8.
- LIST_DEPTH, 4: cache lines.
- LIST_WIDTH, 32: words per line.
- DATA_WIDTH, 32: word width.
- MEM_LAT, 1: SRAM read latency in cycles, 1..4.
- AGE_MAX, 15: denied-cycle threshold for promotion, 1..255.
- Derived RADDR_W = $clog2(LIST_DEPTH)+$clog2(LIST_WIDTH).
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- req_ren  in  NUM_REQ  per-requester read request (mem_ren).
- req_raddr  in  NUM_REQ*RADDR_W  packed word addresses; requester i at [i*RADDR_W +: RADDR_W].
- req_rpri  in  NUM_REQ*2  packed priority; 3 is highest.
- req_rready  out  NUM_REQ  one-hot grant (mem_rready).
- req_rdata  out  DATA_WIDTH  SRAM read data, broadcast to all requesters.
- req_rdata_valid  out  NUM_REQ  one-hot data valid (mem_rdata_valid).
- sram_busy  in  1  write port owns the macro this cycle; no grant is issued.
- sram_ren  out  1  SRAM read enable.
- sram_raddr  out  RADDR_W  SRAM word address.
- sram_rdata  in  DATA_WIDTH  valid MEM_LAT cycles after sram_ren.

## Operation
- A handshake on requester i is `req_ren[i] && req_rready[i]`. The grant is combinational and lands in the same cycle as the request, because requesters sample mem_rready combinationally.
- Eligible requesters have `req_ren` high, and `sram_busy` is low.
- Effective priority: `eff_pri[i]` = 3 if `age[i] == AGE_MAX`, else `req_rpri[i]`.
- Winner: the highest `eff_pri`. Ties are broken round-robin, starting at `rr_ptr` and scanning upward with modulo NUM_REQ wrap.
- On any grant:
  - `rr_ptr` is set to winner+1, wrapping to 0 after NUM_REQ-1.
  - `sram_ren` = 1.
  - `sram_raddr` = the winner's address.
- Age counter per requester, 8 bits:
  - Increments, saturating at AGE_MAX, when `req_ren[i]` is high and i is not granted.
  - Clears to 0 on a grant to i or when `req_ren[i]` is low.
  - A `sram_busy` cycle counts as a denial.
- Valid return: a MEM_LAT-deep shift register of one-hot grant vectors. Stage MEM_LAT-1 drives `req_rdata_valid`. `req_rdata` = `sram_rdata`, always passed through.
- Requesters may drop `req_ren` without being granted. No state is held for a withdrawn request except the age clear.
- Arbiter states: NORMAL, and BLOCKED (`sram_busy` high, all grants masked). State is held only in `rr_ptr`, the ages and the valid pipe; there is no explicit FSM beyond that.

## Timing
- Grant latency is 0 cycles. `req_rdata_valid[i]` pulses exactly MEM_LAT cycles after the handshake, for one cycle.
- Back-to-back grants are allowed every cycle. The valid pipe holds up to MEM_LAT in-flight reads.
- While `rst` is high:
  - `req_rready`, `sram_ren` and `req_rdata_valid` are 0.
  - `sram_raddr` is 0.
  - `rr_ptr`, the ages and the pipe are 0.
- Reset asserted mid-operation drops all in-flight valids. No valid is issued after reset releases for reads launched before it.
- `sram_busy` and a request arriving in the same cycle: no grant, and the age increments.
- A requester at AGE_MAX competing with a native priority-3 requester resolves by round-robin.

## Configuration
- `CACHE_RD_ARB_AGING_EN` defined: age counters and promotion are as above.
- Not defined: no age registers. `eff_pri` = `req_rpri`, i.e. pure priority plus round-robin; a low-priority requester can starve.

## Structure
- Shared package `cache_pkg`:
  - `mem_pri_t` (2-bit priority enum: PRI_LOW=0 .. PRI_URGENT=3).
  - `arb_state_t` (NORMAL, BLOCKED).
  - Function `rr_pick(req, ptr)` returning a one-hot vector.
- One sub-module, `cache_rd_arb_pipe`: the MEM_LAT-deep one-hot valid shift register with asynchronous clear.

## Test plan
- Single request, MEM_LAT=1: `req_ren[0]`=1 with addr 0x2A. Expect `req_rready`=3'b001 in the same cycle, `sram_raddr`=0x2A, and `req_rdata_valid`=3'b001 one cycle later carrying `sram_rdata`.
- Equal priority contention: all three requesters assert with priority 0 continuously. Expect grant order 0,1,2,0,1,2 over 6 cycles.
- Priority: requester 1 at pri 2 and requester 2 at pri 0, both asserted. Expect requester 1 granted every cycle. With aging enabled, requester 2 is granted on cycle 16 (AGE_MAX=15) and then its age clears.
- `sram_busy` high for 3 cycles with requester 0 asserted: no `sram_ren`, no grant. Requester 0 is granted on the cycle `sram_busy` falls.
- MEM_LAT=3 with back-to-back grants to 0,1,2: valids 001, 010, 100 arrive on cycles 3, 4, 5.
- Reset mid-flight: grant at cycle 0 with MEM_LAT=2 and `rst` pulsed at cycle 1. Expect no `req_rdata_valid` afterwards and `rr_ptr`=0, so the next tie goes to requester 0.
